chan_scan_seq: RTL and testbench

Round-robin channel scanner that sits directly upstream of the 4:1 select mux. It drives the mux `sel` input, holds each enabled channel for a programmable dwell time, and captures the mux output `y` into per-channel result registers. It also reports each capture and each completed frame to downstream logic.

---
 rtl/chan_scan_seq.sv | 204 ++++++++++++++++++++
 tb/tb_chan_scan_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/chan_scan_seq.sv
// Round-robin scanner for a 4:1 mux: drives sel, dwells per enabled channel, captures mux_y per channel.
// Optional macro SCAN_FRAME_CNT_EN adds an 8-bit wrapping frame_cnt output.
module chan_scan_seq #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [3:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_y,
    output logic [1:0]         sel,
    output logic               busy,
    output logic               sample_valid,
    output logic [1:0]         sample_ch,
    output logic               sample_bit,
    output logic [3:0]         sample_vec,
    output logic               frame_done
`ifdef SCAN_FRAME_CNT_EN
    ,
    output logic [7:0]         frame_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DWELL   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [1:0]         sel_r, sel_nxt_s;
    logic [3:0]         mask_r, mask_nxt_s;
    logic [DWELL_W-1:0] dw_r, dw_nxt_s;
    logic [DWELL_W-1:0] cnt_r, cnt_nxt_s;
    logic               stop_r, stop_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               sv_r, sv_nxt_s;
    logic [1:0]         sch_r, sch_nxt_s;
    logic               sbit_r, sbit_nxt_s;
    logic [3:0]         svec_r, svec_nxt_s;
    logic               fd_r, fd_nxt_s;
    logic [1:0]         next_ch_s;
    logic               wrap_s;
    logic               stop_eff_s;

    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] r;
        casez (m)
            4'b???1: r = 2'd0;
            4'b??10: r = 2'd1;
            4'b?100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Search forward from cur (exclusive) with wrap; finds cur itself when it is the only enabled channel.
    function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
        logic [1:0] r;
        logic [1:0] idx;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + k[1:0];
            if (!found && m[idx]) begin
                r     = idx;
                found = 1'b1;
            end else begin
                r     = r;
            end
        end
        return r;
    endfunction

    assign next_ch_s  = next_ch(mask_r, sel_r);
    assign wrap_s     = (next_ch_s <= sel_r);
    assign stop_eff_s = stop_r | stop;

    // Next-state, shadow-register and capture logic
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        mask_nxt_s  = mask_r;
        dw_nxt_s    = dw_r;
        cnt_nxt_s   = cnt_r;
        stop_nxt_s  = stop_r;
        sv_nxt_s    = 1'b0;
        fd_nxt_s    = 1'b0;
        sch_nxt_s   = sch_r;
        sbit_nxt_s  = sbit_r;
        svec_nxt_s  = svec_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop && (ch_mask != 4'b0000)) begin
                    state_nxt_s = ST_DWELL;
                    mask_nxt_s  = ch_mask;
                    dw_nxt_s    = dwell;
                    cnt_nxt_s   = dwell;
                    sel_nxt_s   = lowest_ch(ch_mask);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DWELL: begin
                stop_nxt_s = stop_eff_s;
                if (cnt_r == DWELL_W'(0)) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    cnt_nxt_s = cnt_r - DWELL_W'(1);
                end
            end
            ST_CAPTURE: begin
                sv_nxt_s           = 1'b1;
                sch_nxt_s          = sel_r;
                sbit_nxt_s         = mux_y;
                svec_nxt_s[sel_r]  = mux_y;
                if (wrap_s) begin
                    fd_nxt_s   = 1'b1;
                    mask_nxt_s = ch_mask;
                    dw_nxt_s   = dwell;
                    stop_nxt_s = 1'b0;
                    if (stop_eff_s || (ch_mask == 4'b0000)) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DWELL;
                        cnt_nxt_s   = dwell;
                        sel_nxt_s   = lowest_ch(ch_mask);
                    end
                end else begin
                    state_nxt_s = ST_DWELL;
                    stop_nxt_s  = stop_eff_s;
                    cnt_nxt_s   = dw_r;
                    sel_nxt_s   = next_ch_s;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                stop_nxt_s  = 1'b0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            sel_r   <= 2'd0;
            mask_r  <= 4'b0000;
            dw_r    <= '0;
            cnt_r   <= '0;
            stop_r  <= 1'b0;
            busy_r  <= 1'b0;
            sv_r    <= 1'b0;
            sch_r   <= 2'd0;
            sbit_r  <= 1'b0;
            svec_r  <= 4'b0000;
            fd_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            mask_r  <= mask_nxt_s;
            dw_r    <= dw_nxt_s;
            cnt_r   <= cnt_nxt_s;
            stop_r  <= stop_nxt_s;
            busy_r  <= busy_nxt_s;
            sv_r    <= sv_nxt_s;
            sch_r   <= sch_nxt_s;
            sbit_r  <= sbit_nxt_s;
            svec_r  <= svec_nxt_s;
            fd_r    <= fd_nxt_s;
        end
    end

    assign sel          = sel_r;
    assign busy         = busy_r;
    assign sample_valid = sv_r;
    assign sample_ch    = sch_r;
    assign sample_bit   = sbit_r;
    assign sample_vec   = svec_r;
    assign frame_done   = fd_r;

`ifdef SCAN_FRAME_CNT_EN
    logic [7:0] fcnt_r;

    // Frame counter, wraps naturally at 8 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_r <= 8'd0;
        end else if (fd_nxt_s) begin
            fcnt_r <= fcnt_r + 8'd1;
        end else begin
            fcnt_r <= fcnt_r;
        end
    end

    assign frame_cnt = fcnt_r;
`endif

endmodule

// File: tb/tb_chan_scan_seq.sv
// Directed bench for chan_scan_seq; models the downstream 4:1 mux as mux_in[sel].
module tb_chan_scan_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] ch_mask;
    logic [3:0] dwell;
    logic [3:0] mux_in;
    logic       mux_y;
    logic [1:0] sel;
    logic       busy;
    logic       sample_valid;
    logic [1:0] sample_ch;
    logic       sample_bit;
    logic [3:0] sample_vec;
    logic       frame_done;
`ifdef SCAN_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mux_y = mux_in[sel];

    chan_scan_seq #(.DWELL_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .ch_mask      (ch_mask),
        .dwell        (dwell),
        .mux_y        (mux_y),
        .sel          (sel),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_bit   (sample_bit),
        .sample_vec   (sample_vec),
        .frame_done   (frame_done)
`ifdef SCAN_FRAME_CNT_EN
        ,
        .frame_cnt    (frame_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel"},  32'(sel), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sv"},   32'(sample_valid), 32'd0);
        chk({tag, "_ch"},   32'(sample_ch), 32'd0);
        chk({tag, "_bit"},  32'(sample_bit), 32'd0);
        chk({tag, "_vec"},  32'(sample_vec), 32'd0);
        chk({tag, "_fd"},   32'(frame_done), 32'd0);
    endtask

    initial begin
        int exp_ch;
        int nfd;
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        ch_mask = 4'b0000;
        dwell   = 4'd0;
        mux_in  = 4'b0000;
        #2;
        chk_all_zero("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic scan, then stop during ch1 dwell of the second frame
        ch_mask = 4'b1111;
        dwell   = 4'd2;
        mux_in  = 4'b1101;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("b0_sel", 32'(sel), 32'd0);
        chk("b0_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 32; k++) begin
            if (k == 22) stop = 1'b1;
            tick();
            stop = 1'b0;
            chk($sformatf("b%0d_sv", k), 32'(sample_valid), 32'((k % 4) == 0));
            chk($sformatf("b%0d_fd", k), 32'(frame_done), 32'((k == 16) || (k == 32)));
            chk($sformatf("b%0d_busy", k), 32'(busy), 32'(k < 32));
            chk($sformatf("b%0d_sel", k), 32'(sel), (k == 32) ? 32'd3 : 32'((k / 4) % 4));
            if ((k % 4) == 0) begin
                exp_ch = (k / 4 - 1) % 4;
                chk($sformatf("b%0d_ch", k), 32'(sample_ch), 32'(exp_ch));
                chk($sformatf("b%0d_bit", k), 32'(sample_bit), 32'(mux_in[exp_ch]));
            end
        end
        chk("b_vec", 32'(sample_vec), 32'b1101);

        // Restart one cycle later; mask change during ch1
        start  = 1'b1;
        mux_in = 4'b0010;
        tick();
        start = 1'b0;
        chk("m0_sel", 32'(sel), 32'd0);
        chk("m0_busy", 32'(busy), 32'd1);
        chk("m0_sv", 32'(sample_valid), 32'd0);
        for (int j = 1; j <= 24; j++) begin
            if (j == 6)  ch_mask = 4'b0001;
            if (j == 22) ch_mask = 4'b0000;
            tick();
            chk($sformatf("m%0d_sv", j), 32'(sample_valid), 32'((j % 4) == 0));
            chk($sformatf("m%0d_fd", j), 32'(frame_done), 32'((j == 16) || (j == 20) || (j == 24)));
            chk($sformatf("m%0d_busy", j), 32'(busy), 32'(j < 24));
            chk($sformatf("m%0d_sel", j), 32'(sel), (j < 16) ? 32'(j / 4) : 32'd0);
            if ((j % 4) == 0) begin
                exp_ch = (j <= 16) ? (j / 4 - 1) : 0;
                chk($sformatf("m%0d_ch", j), 32'(sample_ch), 32'(exp_ch));
                chk($sformatf("m%0d_bit", j), 32'(sample_bit), 32'(mux_in[exp_ch]));
            end
        end
        chk("m_vec", 32'(sample_vec), 32'b0010);
        tick();
        chk("m_idle_busy", 32'(busy), 32'd0);
        chk("m_idle_sv", 32'(sample_valid), 32'd0);

        // Sparse mask, zero dwell
        ch_mask = 4'b1010;
        dwell   = 4'd0;
        mux_in  = 4'b1000;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("s0_sel", 32'(sel), 32'd1);
        chk("s0_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("s%0d_sv", k), 32'(sample_valid), 32'((k % 2) == 0));
            chk($sformatf("s%0d_fd", k), 32'(frame_done), 32'((k % 4) == 0));
            chk($sformatf("s%0d_sel", k), 32'(sel), ((k % 4) == 2 || (k % 4) == 3) ? 32'd3 : 32'd1);
            if ((k % 2) == 0) begin
                exp_ch = ((k % 4) == 2) ? 1 : 3;
                chk($sformatf("s%0d_ch", k), 32'(sample_ch), 32'(exp_ch));
                chk($sformatf("s%0d_bit", k), 32'(sample_bit), 32'(mux_in[exp_ch]));
            end
        end
        chk("s_vec", 32'(sample_vec), 32'b1000);

        // Asynchronous reset during CAPTURE
        tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        tick();
        tick();
        rst_n = 1'b1;

        // Ignored starts
        ch_mask = 4'b0000;
        start   = 1'b1;
        tick();
        tick();
        chk("ign_mask0_busy", 32'(busy), 32'd0);
        ch_mask = 4'b1111;
        stop    = 1'b1;
        tick();
        chk("ign_stop_busy", 32'(busy), 32'd0);
        tick();
        chk("ign_stop_busy2", 32'(busy), 32'd0);
        start = 1'b0;
        stop  = 1'b0;

        // 257 single-channel frames
`ifdef SCAN_FRAME_CNT_EN
        chk("fc_init", 32'(frame_cnt), 32'd0);
`endif
        ch_mask = 4'b0001;
        dwell   = 4'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        nfd   = 0;
        for (int k = 1; k <= 514; k++) begin
            if (k == 514) ch_mask = 4'b0000;
            tick();
            if (frame_done) nfd++;
        end
        chk("fc_frames", 32'(nfd), 32'd257);
        chk("fc_busy", 32'(busy), 32'd0);
`ifdef SCAN_FRAME_CNT_EN
        chk("fc_cnt", 32'(frame_cnt), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
